// File: rtl/text_terminal_pkg.sv
// -----------------------------------------------------------------------------
// text_terminal_pkg
// Shared definitions for the text terminal writer:
//   - control-code byte values (LF, CR, BS, FF)
//   - printable range bounds
//   - default blank code written by every clear operation
//   - writer FSM state and cursor-register operation enums
//   - is_printable() helper
// -----------------------------------------------------------------------------
package text_terminal_pkg;

    localparam logic [7:0] CHR_BS = 8'h08;
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_FF = 8'h0C;
    localparam logic [7:0] CHR_CR = 8'h0D;

    localparam logic [7:0] CHR_PRINT_LO = 8'h20;
    localparam logic [7:0] CHR_PRINT_HI = 8'h7E;

    localparam logic [7:0] BLANK_CHAR_DEFAULT = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLR_LINE = 2'd1,
        ST_CLR_ALL  = 2'd2
    } state_e;

    // Operations understood by a text_cursor_pos register pair.
    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_ADVANCE = 3'd1,  // col+1, wrapping into the next row
        OP_NEWLINE = 3'd2,  // col=0, row+1 (wrapping)
        OP_CR      = 3'd3,  // col=0
        OP_BS      = 3'd4,  // col-1, saturating at 0
        OP_HOME    = 3'd5   // (0,0)
    } cursor_op_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= CHR_PRINT_LO) && (b <= CHR_PRINT_HI);
    endfunction

endpackage

// File: rtl/text_terminal_writer_if.sv
// -----------------------------------------------------------------------------
// text_terminal_writer_if
// Bundles the byte input stream and the character-buffer / cursor outputs of
// the text terminal writer.
//   master : the writer (consumes in_valid/in_data, drives everything else)
//   slave  : the environment (byte source + character buffer)
// Signals:
//   in_valid, in_data[7:0], in_ready       byte stream, valid/ready
//   char_write_en, char_hpos, char_vpos,
//   char_symbol[7:0]                       one-cycle cell write
//   cursor_valid, cursor_hpos, cursor_vpos cursor position
//   busy                                   clear sweep in progress
// -----------------------------------------------------------------------------
interface text_terminal_writer_if #(
    parameter int CHAR_HORZ_W = 4,
    parameter int CHAR_VERT_W = 1
);
    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_ready;

    logic                   char_write_en;
    logic [CHAR_HORZ_W-1:0] char_hpos;
    logic [CHAR_VERT_W-1:0] char_vpos;
    logic [7:0]             char_symbol;

    logic                   cursor_valid;
    logic [CHAR_HORZ_W-1:0] cursor_hpos;
    logic [CHAR_VERT_W-1:0] cursor_vpos;

    logic                   busy;

    modport master (
        input  in_valid, in_data,
        output in_ready,
        output char_write_en, char_hpos, char_vpos, char_symbol,
        output cursor_valid, cursor_hpos, cursor_vpos,
        output busy
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready,
        input  char_write_en, char_hpos, char_vpos, char_symbol,
        input  cursor_valid, cursor_hpos, cursor_vpos,
        input  busy
    );
endinterface

// File: rtl/text_cursor_pos.sv
// -----------------------------------------------------------------------------
// text_cursor_pos
// Column/row register pair for a H_CNT x V_CNT character grid. Used both as
// the visible text cursor and as the clear-sweep address counter.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (position -> (0,0))
//   op_i          operation applied at the next clock edge
//   col_o, row_o  current position (registered)
//   last_col_o    col_o == H_CNT-1
//   wrap_o        op_i would move the row past V_CNT-1 back to row 0
// Last column/row are found by equality with CNT-1, so non-power-of-2 grid
// sizes wrap correctly.
// -----------------------------------------------------------------------------
module text_cursor_pos
    import text_terminal_pkg::*;
#(
    parameter int H_CNT = 16,
    parameter int V_CNT = 2,
    parameter int H_W   = $clog2(H_CNT),
    parameter int V_W   = $clog2(V_CNT)
) (
    input  logic           clk,
    input  logic           rst,
    input  cursor_op_e     op_i,
    output logic [H_W-1:0] col_o,
    output logic [V_W-1:0] row_o,
    output logic           last_col_o,
    output logic           wrap_o
);

    localparam logic [H_W-1:0] LAST_COL = H_W'(H_CNT - 1);
    localparam logic [V_W-1:0] LAST_ROW = V_W'(V_CNT - 1);

    logic [H_W-1:0] col_q, col_d;
    logic [V_W-1:0] row_q, row_d;
    logic           last_col;
    logic           last_row;
    logic [V_W-1:0] next_row;

    assign last_col = (col_q == LAST_COL);
    assign last_row = (row_q == LAST_ROW);
    assign next_row = last_row ? '0 : row_q + V_W'(1);

    always_comb begin
        // NOTE: hold values are assigned first so every path drives col_d/row_d; otherwise a latch is inferred.
        col_d = col_q;
        row_d = row_q;
        unique case (op_i)
            OP_ADVANCE: begin
                if (last_col) begin
                    col_d = '0;
                    row_d = next_row;
                end else begin
                    col_d = col_q + H_W'(1);
                end
            end
            OP_NEWLINE: begin
                col_d = '0;
                row_d = next_row;
            end
            OP_CR: col_d = '0;
            OP_BS: begin
                if (col_q != '0) col_d = col_q - H_W'(1);
            end
            OP_HOME: begin
                col_d = '0;
                row_d = '0;
            end
            default: ;
        endcase
    end

    assign wrap_o = last_row &&
                    (((op_i == OP_ADVANCE) && last_col) || (op_i == OP_NEWLINE));

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o      = col_q;
    assign row_o      = row_q;
    assign last_col_o = last_col;

endmodule

// File: rtl/text_terminal_writer.sv
// -----------------------------------------------------------------------------
// text_terminal_writer
// Turns an 8-bit character stream into character-buffer cell writes and a
// cursor position. Handles printable bytes (0x20..0x7E), CR, LF (implicit
// CR+LF), BS and FF (clear screen); auto-wraps at line end. Moving past the
// last row returns to row 0 and blanks that row first (no scrolling: the
// buffer cannot be read back).
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset
//   term_if  text_terminal_writer_if.master:
//              in_valid/in_data/in_ready  byte input, valid/ready
//              char_write_en/hpos/vpos/symbol  registered cell write strobe
//              cursor_valid/hpos/vpos     cursor (valid only while idle)
//              busy                       clear sweep in progress
// Optional feature (macro TEXT_TERMINAL_CLEAR_ON_RESET_EN):
//   defined   -> leaves reset in CLR_ALL and blanks the whole screen first
//   undefined -> leaves reset in IDLE, buffer contents untouched
// Timing: a byte accepted at cycle N shows its write and the new cursor at
// N+1. Clear sweeps emit one blank per cycle; in_ready returns the cycle
// after the last blank write.
// -----------------------------------------------------------------------------
module text_terminal_writer
    import text_terminal_pkg::*;
#(
    parameter int         CHAR_HORZ_CNT = 16,
    parameter int         CHAR_VERT_CNT = 2,
    parameter int         CHAR_HORZ_W   = $clog2(CHAR_HORZ_CNT),
    parameter int         CHAR_VERT_W   = $clog2(CHAR_VERT_CNT),
    parameter logic [7:0] BLANK_CHAR    = BLANK_CHAR_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    text_terminal_writer_if.master term_if
);

`ifdef TEXT_TERMINAL_CLEAR_ON_RESET_EN
    localparam state_e RESET_STATE = ST_CLR_ALL;
    localparam logic   RESET_IDLE  = 1'b0;
`else
    localparam state_e RESET_STATE = ST_IDLE;
    localparam logic   RESET_IDLE  = 1'b1;
`endif

    // FSM and registered outputs
    state_e                 state_q;
    logic                   idle_q;      // drives in_ready and cursor_valid
    logic                   busy_q;
    logic                   done_q;      // last blank of the sweep has been emitted
    logic                   wr_en_q;
    logic [CHAR_HORZ_W-1:0] wr_hpos_q;
    logic [CHAR_VERT_W-1:0] wr_vpos_q;
    logic [7:0]             wr_sym_q;

    // Cursor and sweep position registers
    cursor_op_e             cursor_op;
    logic [CHAR_HORZ_W-1:0] cursor_col;
    logic [CHAR_VERT_W-1:0] cursor_row;
    logic                   cursor_wrap;
    logic                   unused_cursor_last_col;  // text cursor only needs its wrap flag

    cursor_op_e             sweep_op;
    logic [CHAR_HORZ_W-1:0] sweep_col;
    logic [CHAR_VERT_W-1:0] sweep_row;
    logic                   sweep_last_col;
    logic                   sweep_wrap;

    logic                   accept;
    logic [7:0]             in_byte;

    assign in_byte = term_if.in_data;
    assign accept  = term_if.in_valid && idle_q;

    text_cursor_pos #(
        .H_CNT (CHAR_HORZ_CNT),
        .V_CNT (CHAR_VERT_CNT),
        .H_W   (CHAR_HORZ_W),
        .V_W   (CHAR_VERT_W)
    ) u_cursor (
        .clk        (clk),
        .rst        (rst),
        .op_i       (cursor_op),
        .col_o      (cursor_col),
        .row_o      (cursor_row),
        .last_col_o (unused_cursor_last_col),
        .wrap_o     (cursor_wrap)
    );

    // The sweep counter rests at (0,0) whenever the FSM is idle, so a sweep
    // always starts there. For LF-wrap and FF the blank at (0,0) is emitted
    // on the acceptance edge itself, so the counter steps past it right away.
    text_cursor_pos #(
        .H_CNT (CHAR_HORZ_CNT),
        .V_CNT (CHAR_VERT_CNT),
        .H_W   (CHAR_HORZ_W),
        .V_W   (CHAR_VERT_W)
    ) u_sweep (
        .clk        (clk),
        .rst        (rst),
        .op_i       (sweep_op),
        .col_o      (sweep_col),
        .row_o      (sweep_row),
        .last_col_o (sweep_last_col),
        .wrap_o     (sweep_wrap)
    );

    always_comb begin
        cursor_op = OP_NONE;
        if (accept) begin
            if (is_printable(in_byte)) begin
                cursor_op = OP_ADVANCE;
            end else begin
                case (in_byte)
                    CHR_LF:  cursor_op = OP_NEWLINE;
                    CHR_CR:  cursor_op = OP_CR;
                    CHR_BS:  cursor_op = OP_BS;
                    CHR_FF:  cursor_op = OP_HOME;
                    default: cursor_op = OP_NONE;
                endcase
            end
        end
    end

    always_comb begin
        sweep_op = OP_NONE;
        if (state_q != ST_IDLE) begin
            sweep_op = done_q ? OP_HOME : OP_ADVANCE;
        end else if (accept && (((in_byte == CHR_LF) && cursor_wrap) ||
                                (in_byte == CHR_FF))) begin
            sweep_op = OP_ADVANCE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RESET_STATE;
            idle_q    <= RESET_IDLE;
            busy_q    <= !RESET_IDLE;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_hpos_q <= '0;
            wr_vpos_q <= '0;
            wr_sym_q  <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_printable(in_byte)) begin
                            wr_en_q   <= 1'b1;
                            wr_hpos_q <= cursor_col;
                            wr_vpos_q <= cursor_row;
                            wr_sym_q  <= in_byte;
                            // Row 0 is blanked after the character itself lands.
                            if (cursor_wrap) begin
                                state_q <= ST_CLR_LINE;
                                idle_q  <= 1'b0;
                                busy_q  <= 1'b1;
                                done_q  <= 1'b0;
                            end
                        end else if (in_byte == CHR_LF) begin
                            // No character write, so the first blank goes out now.
                            if (cursor_wrap) begin
                                wr_en_q   <= 1'b1;
                                wr_hpos_q <= '0;
                                wr_vpos_q <= '0;
                                wr_sym_q  <= BLANK_CHAR;
                                state_q   <= ST_CLR_LINE;
                                idle_q    <= 1'b0;
                                busy_q    <= 1'b1;
                                done_q    <= sweep_last_col;
                            end
                        end else if (in_byte == CHR_BS) begin
                            if (cursor_col != '0) begin
                                wr_en_q   <= 1'b1;
                                wr_hpos_q <= cursor_col - CHAR_HORZ_W'(1);
                                wr_vpos_q <= cursor_row;
                                wr_sym_q  <= BLANK_CHAR;
                            end
                        end else if (in_byte == CHR_FF) begin
                            wr_en_q   <= 1'b1;
                            wr_hpos_q <= '0;
                            wr_vpos_q <= '0;
                            wr_sym_q  <= BLANK_CHAR;
                            state_q   <= ST_CLR_ALL;
                            idle_q    <= 1'b0;
                            busy_q    <= 1'b1;
                            done_q    <= sweep_wrap;
                        end
                    end
                end

                ST_CLR_LINE, ST_CLR_ALL: begin
                    if (done_q) begin
                        state_q <= ST_IDLE;
                        idle_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        // Sweep row stays 0 for the whole of a line clear.
                        wr_en_q   <= 1'b1;
                        wr_hpos_q <= sweep_col;
                        wr_vpos_q <= sweep_row;
                        wr_sym_q  <= BLANK_CHAR;
                        done_q    <= (state_q == ST_CLR_LINE) ? sweep_last_col : sweep_wrap;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    idle_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign term_if.in_ready      = idle_q;
    assign term_if.cursor_valid  = idle_q;
    assign term_if.busy          = busy_q;
    assign term_if.char_write_en = wr_en_q;
    assign term_if.char_hpos     = wr_hpos_q;
    assign term_if.char_vpos     = wr_vpos_q;
    assign term_if.char_symbol   = wr_sym_q;
    assign term_if.cursor_hpos   = cursor_col;
    assign term_if.cursor_vpos   = cursor_row;

endmodule
